sid_bus_if_mc: RTL and testbench

Parametrised, multi-chip-select successor to the 6510 bus interface. It debounces the CPU bus with configurable depth and recovers PHI2 edges asymmetrically. It decodes up to NCS chip selects into a one-hot channel select, so several SID cores can sit behind one bus. It supports register writes and, unlike the previous interface, real bus reads with timed data-bus drive, plus PHI2 loss detection. Pad buffers stay outside the block; it sits between the I/O ring and the SID register files.

---
 rtl/sid_bus_if_mc.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_sid_bus_if_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_bus_if_mc.sv
// Multi-chip-select 6510-style bus interface: pad sampling, debounce, PHI2 edge
// recovery, one-hot channel decode, write/read strobes and PHI2 loss detection.
module sid_bus_if_mc_db #(
    parameter int   W       = 1,
    parameter int   DB_LEN  = 4,
    parameter logic RST_ONE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);
    localparam logic [3:0] CNT_MAX = 4'(DB_LEN);
    localparam logic [3:0] CNT_RST = RST_ONE ? CNT_MAX : 4'd0;

    for (genvar g = 0; g < W; g++) begin : g_bit
        logic [3:0] cnt_q;
        logic [3:0] cnt_d;
        logic       out_q;
        logic       out_d;

        // Saturating counter with hysteresis: output only flips at the rails.
        always_comb begin
            cnt_d = cnt_q;
            out_d = out_q;
            if (din_i[g]) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            if (cnt_d == CNT_MAX) begin
                out_d = 1'b1;
            end else if (cnt_d == 4'd0) begin
                out_d = 1'b0;
            end else begin
                out_d = out_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= CNT_RST;
                out_q <= RST_ONE;
            end else begin
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end

        assign dout_o[g] = out_q;
    end
endmodule

module sid_bus_if_mc #(
    parameter int AW            = 5,
    parameter int NCS           = 2,
    parameter int DB_LEN        = 4,
    parameter int PHI2_RISE_LEN = 7,
    parameter int RD_EN         = 1,
    parameter int RD_LAT        = 1,
    parameter int HOLD_LEN      = 2,
    parameter int TO_W          = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   pad_a_i,
    input  logic [7:0]      pad_d_i,
    output logic [7:0]      pad_d_o,
    output logic            pad_d_oe,
    input  logic            pad_r_wn_i,
    input  logic [NCS-1:0]  pad_csn_i,
    input  logic            pad_phi2_i,
    output logic [AW-1:0]   bus_addr,
    output logic [NCS-1:0]  bus_cs,
    output logic [7:0]      bus_wdata,
    output logic            bus_we,
    output logic            bus_re,
    input  logic [7:0]      bus_rdata,
    output logic            clk_en,
    output logic            phi2_lost
);
    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_RISING  = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [3:0] RISE_LAST  = 4'(PHI2_RISE_LEN - 1);
    localparam logic [1:0] LAT_START  = 2'(RD_LAT);
    localparam logic [2:0] HOLD_START = (HOLD_LEN == 0) ? 3'd1 : 3'(HOLD_LEN);

    logic [AW-1:0]  a_in_q;
    logic [7:0]     d_in_q;
    logic           rwn_in_q;
    logic [NCS-1:0] csn_in_q;
    logic           phi2_in_q;

    logic [AW-1:0]  db_a_s;
    logic [7:0]     db_d_s;
    logic [0:0]     db_rwn_s;
    logic [NCS-1:0] db_csn_s;

    logic [1:0]      state_q, state_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic            rise_s, fall_s;
    logic [NCS-1:0]  sel_s;
    logic            any_s;
    logic            wr_go_s, rd_go_s;

    logic [AW-1:0]   addr_q, addr_d;
    logic [NCS-1:0]  cs_q, cs_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            we_q, we_d, re_q, re_d, ce_q, ce_d;
    logic [7:0]      dout_q, dout_d;
    logic            oe_q, oe_d;
    logic [1:0]      lat_q, lat_d;
    logic [2:0]      hold_q, hold_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            lost_q, lost_d;

    // Pad input register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_in_q    <= {AW{1'b0}};
            d_in_q    <= 8'h00;
            rwn_in_q  <= 1'b1;
            csn_in_q  <= {NCS{1'b1}};
            phi2_in_q <= 1'b0;
        end else begin
            a_in_q    <= pad_a_i;
            d_in_q    <= pad_d_i;
            rwn_in_q  <= pad_r_wn_i;
            csn_in_q  <= pad_csn_i;
            phi2_in_q <= pad_phi2_i;
        end
    end

    sid_bus_if_mc_db #(.W(AW),  .DB_LEN(DB_LEN), .RST_ONE(1'b0)) u_db_a
        (.clk(clk), .rst(rst), .din_i(a_in_q),   .dout_o(db_a_s));
    sid_bus_if_mc_db #(.W(8),   .DB_LEN(DB_LEN), .RST_ONE(1'b0)) u_db_d
        (.clk(clk), .rst(rst), .din_i(d_in_q),   .dout_o(db_d_s));
    sid_bus_if_mc_db #(.W(1),   .DB_LEN(DB_LEN), .RST_ONE(1'b1)) u_db_rwn
        (.clk(clk), .rst(rst), .din_i(rwn_in_q), .dout_o(db_rwn_s));
    sid_bus_if_mc_db #(.W(NCS), .DB_LEN(DB_LEN), .RST_ONE(1'b1)) u_db_csn
        (.clk(clk), .rst(rst), .din_i(csn_in_q), .dout_o(db_csn_s));

    // PHI2 edge recovery: a rise needs PHI2_RISE_LEN consecutive high samples.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        case (state_q)
            ST_LOW, ST_RISING: begin
                if (phi2_in_q) begin
                    if (rcnt_q == RISE_LAST) begin
                        state_d = ST_HIGH;
                        rcnt_d  = 4'd0;
                        rise_s  = 1'b1;
                    end else begin
                        state_d = ST_RISING;
                        rcnt_d  = rcnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_LOW;
                    rcnt_d  = 4'd0;
                end
            end
            ST_HIGH: begin
                if (!phi2_in_q) begin
                    state_d = ST_LOW;
                    fall_s  = 1'b1;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            default: begin
                state_d = ST_LOW;
                rcnt_d  = 4'd0;
            end
        endcase
    end

    // Lowest-index active chip select wins.
    always_comb begin
        sel_s = {NCS{1'b0}};
        any_s = 1'b0;
        for (int i = 0; i < NCS; i++) begin
            if (!db_csn_s[i] && !any_s) begin
                sel_s[i] = 1'b1;
                any_s    = 1'b1;
            end else begin
                sel_s[i] = 1'b0;
            end
        end
    end

    assign wr_go_s = fall_s & ~db_rwn_s[0] & any_s;
    assign rd_go_s = (RD_EN != 0) & rise_s & db_rwn_s[0] & any_s;

    // Access strobes, read-data drive window and PHI2 timeout.
    always_comb begin
        addr_d  = addr_q;
        cs_d    = cs_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        ce_d    = fall_s;
        dout_d  = dout_q;
        oe_d    = oe_q;
        lat_d   = lat_q;
        hold_d  = hold_q;

        if (wr_go_s) begin
            addr_d  = db_a_s;
            cs_d    = sel_s;
            wdata_d = db_d_s;
            we_d    = 1'b1;
        end else begin
            we_d    = 1'b0;
        end

        if (rd_go_s) begin
            addr_d = db_a_s;
            cs_d   = sel_s;
            re_d   = 1'b1;
            lat_d  = LAT_START;
        end else if (lat_q != 2'd0) begin
            lat_d = lat_q - 2'd1;
            if (lat_q == 2'd1) begin
                dout_d = bus_rdata;
                oe_d   = 1'b1;
            end else begin
                oe_d   = oe_q;
            end
        end else begin
            lat_d = lat_q;
        end

        // Hold window opens on the fall and closes the drive when it expires.
        if (rd_go_s) begin
            hold_d = 3'd0;
        end else if (fall_s && (oe_q || (lat_q != 2'd0))) begin
            hold_d = HOLD_START;
        end else if (hold_q != 3'd0) begin
            hold_d = hold_q - 3'd1;
            if (hold_q == 3'd1) begin
                oe_d = 1'b0;
            end else begin
                oe_d = oe_d;
            end
        end else begin
            hold_d = hold_q;
        end

        if (!db_rwn_s[0]) begin
            oe_d = 1'b0;
        end else begin
            oe_d = oe_d;
        end

        if (fall_s) begin
            to_d = {TO_W{1'b0}};
        end else if (&to_q) begin
            to_d = to_q;
        end else begin
            to_d = to_q + TO_W'(1);
        end
        lost_d = &to_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            rcnt_q  <= 4'd0;
            addr_q  <= {AW{1'b0}};
            cs_q    <= {NCS{1'b0}};
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            ce_q    <= 1'b0;
            dout_q  <= 8'h00;
            oe_q    <= 1'b0;
            lat_q   <= 2'd0;
            hold_q  <= 3'd0;
            to_q    <= {TO_W{1'b0}};
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            ce_q    <= ce_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            lat_q   <= lat_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            lost_q  <= lost_d;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_cs    = cs_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign bus_re    = re_q;
    assign clk_en    = ce_q;
    assign pad_d_o   = dout_q;
    assign pad_d_oe  = oe_q;
    assign phi2_lost = lost_q;
endmodule

// File: tb/tb_sid_bus_if_mc.sv
// Directed bench for sid_bus_if_mc: a write table plus hand-written read,
// glitch, reset and timeout sequences on a default and a read-disabled instance.
module tb_sid_bus_if_mc;
    logic       clk;
    logic       rst;
    logic [4:0] pad_a_i;
    logic [7:0] pad_d_i;
    logic       pad_r_wn_i;
    logic [1:0] pad_csn_i;
    logic       pad_phi2_i;
    logic [7:0] bus_rdata;

    logic [7:0] pad_d_o,   pad_d_o2;
    logic       pad_d_oe,  pad_d_oe2;
    logic [4:0] bus_addr,  bus_addr2;
    logic [1:0] bus_cs,    bus_cs2;
    logic [7:0] bus_wdata, bus_wdata2;
    logic       bus_we,    bus_we2;
    logic       bus_re,    bus_re2;
    logic       clk_en,    clk_en2;
    logic       phi2_lost, phi2_lost2;

    sid_bus_if_mc u_dut (
        .clk(clk), .rst(rst), .pad_a_i(pad_a_i), .pad_d_i(pad_d_i),
        .pad_d_o(pad_d_o), .pad_d_oe(pad_d_oe), .pad_r_wn_i(pad_r_wn_i),
        .pad_csn_i(pad_csn_i), .pad_phi2_i(pad_phi2_i), .bus_addr(bus_addr),
        .bus_cs(bus_cs), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .clk_en(clk_en), .phi2_lost(phi2_lost)
    );

    sid_bus_if_mc #(.RD_EN(0), .TO_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .pad_a_i(pad_a_i), .pad_d_i(pad_d_i),
        .pad_d_o(pad_d_o2), .pad_d_oe(pad_d_oe2), .pad_r_wn_i(pad_r_wn_i),
        .pad_csn_i(pad_csn_i), .pad_phi2_i(pad_phi2_i), .bus_addr(bus_addr2),
        .bus_cs(bus_cs2), .bus_wdata(bus_wdata2), .bus_we(bus_we2), .bus_re(bus_re2),
        .bus_rdata(bus_rdata), .clk_en(clk_en2), .phi2_lost(phi2_lost2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] csn;
        logic [4:0] a;
        logic [7:0] d;
        int         exp_we;
        logic [1:0] exp_cs;
        logic [4:0] exp_a;
        logic [7:0] exp_d;
    } wvec_t;

    wvec_t wv[5];

    int checks = 0;
    int errors = 0;
    int sn, we_n, re_n, ce_n, oe_n, re2_n, oe2_n;
    int we_at, re_at, ce_at, oe_at, off_at;
    logic [4:0] re_addr;
    logic [1:0] re_cs;
    logic [7:0] oe_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        sn = 0; we_n = 0; re_n = 0; ce_n = 0; oe_n = 0; re2_n = 0; oe2_n = 0;
        we_at = 0; re_at = 0; ce_at = 0; oe_at = 0; off_at = 0;
        re_addr = 5'h00; re_cs = 2'b00; oe_data = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        sn++;
        if (bus_we) begin we_n++; if (we_at == 0) we_at = sn; end
        if (bus_re) begin
            re_n++;
            if (re_at == 0) begin re_at = sn; re_addr = bus_addr; re_cs = bus_cs; end
        end
        if (clk_en) begin ce_n++; if (ce_at == 0) ce_at = sn; end
        if (pad_d_oe) begin
            oe_n++;
            if (oe_at == 0) begin oe_at = sn; oe_data = pad_d_o; end
        end else if (off_at == 0) begin
            off_at = sn;
        end
        if (bus_re2) re2_n++;
        if (pad_d_oe2) oe2_n++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_addr"},  32'(bus_addr),  32'h0);
        check({pfx, "_cs"},    32'(bus_cs),    32'h0);
        check({pfx, "_wdata"}, 32'(bus_wdata), 32'h0);
        check({pfx, "_we"},    32'(bus_we),    32'h0);
        check({pfx, "_re"},    32'(bus_re),    32'h0);
        check({pfx, "_clk_en"},32'(clk_en),    32'h0);
        check({pfx, "_d_o"},   32'(pad_d_o),   32'h0);
        check({pfx, "_oe"},    32'(pad_d_oe),  32'h0);
        check({pfx, "_lost"},  32'(phi2_lost), 32'h0);
    endtask

    initial begin
        bit found;
        wv[0] = '{csn: 2'b01, a: 5'h18, d: 8'hA5, exp_we: 1, exp_cs: 2'b10, exp_a: 5'h18, exp_d: 8'hA5};
        wv[1] = '{csn: 2'b10, a: 5'h03, d: 8'h5A, exp_we: 1, exp_cs: 2'b01, exp_a: 5'h03, exp_d: 8'h5A};
        wv[2] = '{csn: 2'b00, a: 5'h1F, d: 8'hFF, exp_we: 1, exp_cs: 2'b01, exp_a: 5'h1F, exp_d: 8'hFF};
        wv[3] = '{csn: 2'b11, a: 5'h07, d: 8'h11, exp_we: 0, exp_cs: 2'b01, exp_a: 5'h1F, exp_d: 8'hFF};
        wv[4] = '{csn: 2'b01, a: 5'h00, d: 8'h00, exp_we: 1, exp_cs: 2'b10, exp_a: 5'h00, exp_d: 8'h00};

        rst = 1'b1; pad_a_i = 5'h00; pad_d_i = 8'h00; pad_r_wn_i = 1'b1;
        pad_csn_i = 2'b11; pad_phi2_i = 1'b0; bus_rdata = 8'h00;
        clr();
        steps(2);
        check_zero("rst");
        check("rst2_oe", 32'(pad_d_oe2), 32'h0);
        check("rst2_lost", 32'(phi2_lost2), 32'h0);
        rst = 1'b0;

        // Write table
        for (int i = 0; i < 5; i++) begin
            pad_csn_i = wv[i].csn; pad_a_i = wv[i].a; pad_d_i = wv[i].d; pad_r_wn_i = 1'b0;
            steps(6);
            clr();
            pad_phi2_i = 1'b1;
            steps(10);
            pad_phi2_i = 1'b0;
            steps(6);
            check($sformatf("wr%0d_we_cnt", i), 32'(we_n), 32'(wv[i].exp_we));
            check($sformatf("wr%0d_ce_cnt", i), 32'(ce_n), 32'd1);
            check($sformatf("wr%0d_re_cnt", i), 32'(re_n), 32'd0);
            check($sformatf("wr%0d_oe_cnt", i), 32'(oe_n), 32'd0);
            check($sformatf("wr%0d_addr", i), 32'(bus_addr), 32'(wv[i].exp_a));
            check($sformatf("wr%0d_cs", i), 32'(bus_cs), 32'(wv[i].exp_cs));
            check($sformatf("wr%0d_wdata", i), 32'(bus_wdata), 32'(wv[i].exp_d));
            if (wv[i].exp_we != 0) check($sformatf("wr%0d_we_with_ce", i), 32'(we_at), 32'(ce_at));
        end

        // Read on channel 0
        pad_csn_i = 2'b10; pad_r_wn_i = 1'b1; pad_a_i = 5'h1B; bus_rdata = 8'h3C;
        steps(8);
        clr();
        pad_phi2_i = 1'b1;
        steps(14);
        check("rd_re_cycle", 32'(re_at), 32'd8);
        check("rd_re_cnt", 32'(re_n), 32'd1);
        check("rd_addr", 32'(re_addr), 32'h1B);
        check("rd_cs", 32'(re_cs), 32'h1);
        check("rd_oe_cycle", 32'(oe_at), 32'd9);
        check("rd_d_o", 32'(oe_data), 32'h3C);
        check("rd_no_we", 32'(we_n), 32'd0);
        check("rd_dis_re", 32'(re2_n), 32'd0);
        check("rd_dis_oe", 32'(oe2_n), 32'd0);
        clr();
        pad_phi2_i = 1'b0;
        steps(8);
        check("rd_fall_ce_cycle", 32'(ce_at), 32'd2);
        check("rd_oe_off_cycle", 32'(off_at), 32'd4);
        check("rd_dis_oe_after", 32'(oe2_n), 32'd0);

        // PHI2 glitch of 3 high samples
        clr();
        pad_phi2_i = 1'b1;
        steps(3);
        pad_phi2_i = 1'b0;
        steps(12);
        check("glitch_re_cnt", 32'(re_n), 32'd0);
        check("glitch_ce_cnt", 32'(ce_n), 32'd0);

        // 3-cycle csn blip straddling a write fall
        pad_r_wn_i = 1'b0; pad_csn_i = 2'b11; pad_a_i = 5'h05; pad_d_i = 8'h66;
        steps(6);
        pad_phi2_i = 1'b1;
        steps(10);
        clr();
        pad_csn_i = 2'b10;
        steps(3);
        pad_csn_i = 2'b11; pad_phi2_i = 1'b0;
        steps(8);
        check("blip_we_cnt", 32'(we_n), 32'd0);
        check("blip_ce_cnt", 32'(ce_n), 32'd1);
        check("hold_addr", 32'(bus_addr), 32'h1B);
        check("hold_wdata", 32'(bus_wdata), 32'h00);
        check("hold_d_o", 32'(pad_d_o), 32'h3C);

        // Reset in the middle of a driven read, PHI2 held high across it
        pad_r_wn_i = 1'b1; pad_csn_i = 2'b10; pad_a_i = 5'h1B;
        steps(8);
        clr();
        pad_phi2_i = 1'b1;
        for (int j = 0; j < 15 && !pad_d_oe; j++) step();
        check("mid_oe_before_rst", 32'(pad_d_oe), 32'h1);
        rst = 1'b1;
        step();
        check_zero("mid_rst");
        rst = 1'b0;
        clr();
        steps(12);
        check("post_rst_re_cycle", 32'(re_at), 32'd8);
        check("post_rst_ce_cnt", 32'(ce_n), 32'd0);
        check("post_rst_addr", 32'(re_addr), 32'h1B);

        // PHI2 timeout on the TO_W=4 instance
        pad_phi2_i = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 10 && !found; j++) begin
            step();
            if (clk_en2) found = 1'b1;
        end
        check("to_fall_seen", 32'(found), 32'h1);
        check("to_lost_at_fall", 32'(phi2_lost2), 32'h0);
        steps(14);
        check("to_lost_14", 32'(phi2_lost2), 32'h0);
        step();
        check("to_lost_15", 32'(phi2_lost2), 32'h1);
        pad_phi2_i = 1'b1;
        steps(10);
        check("to_lost_held", 32'(phi2_lost2), 32'h1);
        pad_phi2_i = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 10 && !found; j++) begin
            step();
            if (clk_en2) found = 1'b1;
        end
        check("to_fall2_seen", 32'(found), 32'h1);
        check("to_lost_cleared", 32'(phi2_lost2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
